// File: rtl/sma_window_buffer_if.sv
// Handshake and window bus between the sample source, the window buffer and the adder tree.
// The master modport is the upstream/downstream environment; the slave modport is the buffer.
interface sma_window_buffer_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUFFER_SIZE = 4,
    parameter int unsigned CNT_WIDTH   = $clog2(BUFFER_SIZE + 1)
) ();
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              out_ready;
    logic                              out_valid;
    logic [DATA_WIDTH*BUFFER_SIZE-1:0] data_out_vector;
    logic [CNT_WIDTH-1:0]              fill_count;
    logic                              full;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, data_out_vector, fill_count, full
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, data_out_vector, fill_count, full
    );
endinterface

// File: rtl/sma_window_buffer.sv
// Sliding-window shift register feeding the SMA adder tree; slot 0 is the newest sample.
// out_valid flags a full window that has not yet been consumed downstream.
module sma_window_buffer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUFFER_SIZE = 4,
    parameter int unsigned CNT_WIDTH   = $clog2(BUFFER_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    sma_window_buffer_if.slave bus
);
    typedef enum logic [0:0] {StFill, StRun} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(BUFFER_SIZE);

    state_e                                 state_q, state_d;
    logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   full_q, full_d;
    logic                                   accept;

    // Stalls only while an unconsumed window is held; clear deliberately does not gate it.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !clear;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = StFill;
            win_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            win_d = {win_q[BUFFER_SIZE-2:0], bus.in_data};
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            unique case (state_q)
                StFill: begin
                    if (cnt_d == CntMax) begin
                        state_d     = StRun;
                        out_valid_d = 1'b1;
                    end
                end
                StRun: out_valid_d = 1'b1;
            endcase
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        full_d = (cnt_d == CntMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            win_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.data_out_vector = win_q;
    assign bus.fill_count      = cnt_q;
    assign bus.full            = full_q;
endmodule

// File: tb/tb_sma_window_buffer.sv
// Bench for sma_window_buffer: directed vector table, async reset checks and a
// randomized run against a queue-based window model.
module tb_sma_window_buffer;
    localparam int unsigned DW = 8;
    localparam int unsigned BS = 4;
    localparam int unsigned CW = $clog2(BS + 1);
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    sma_window_buffer_if #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .CNT_WIDTH(CW)) bus ();

    sma_window_buffer #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          clr;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ir;     // in_ready before the edge
        logic          ov;     // outputs after the edge
        logic [31:0]   vec;
        logic [CW-1:0] fill;
        logic          full;
    } row_t;

    row_t tbl[20];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [DW-1:0] mq[$];
    logic          mv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic clr, input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [31:0] vec, input logic [CW-1:0] fill,
                                input logic full);
        row_t r;
        r.clr = clr; r.iv = iv; r.d = d; r.ordy = ordy; r.ir = ir;
        r.ov = ov; r.vec = vec; r.fill = fill; r.full = full;
        return r;
    endfunction

    task automatic apply(input logic c, input logic iv, input logic [DW-1:0] d, input logic ordy);
        clear        = c;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*BS-1:0] model_vec();
        logic [DW*BS-1:0] v = '0;
        for (int k = 0; k < int'(mq.size()); k++) v[k*DW +: DW] = mq[k];
        return v;
    endfunction

    // Window model: newest sample at the queue front, at most BS entries kept.
    task automatic model_step(input logic c, input logic iv, input logic [DW-1:0] d,
                              input logic ordy);
        logic rdy = !mv || ordy;
        if (c) begin
            mq.delete();
            mv = 1'b0;
        end else if (iv && rdy) begin
            mq.push_front(d);
            if (mq.size() > BS) void'(mq.pop_back());
            mv = (mq.size() == BS);
        end else if (mv && ordy) begin
            mv = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vec"},  64'(bus.data_out_vector), 64'd0);
        chk({tag, " fill"}, 64'(bus.fill_count), 64'd0);
        chk({tag, " ov"},   64'(bus.out_valid), 64'd0);
        chk({tag, " full"}, 64'(bus.full), 64'd0);
        chk({tag, " ir"},   64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        tbl[0]  = mk(F, T, 8'h01, T, T, F, 32'h00000001, 3'd1, F);
        tbl[1]  = mk(F, T, 8'h02, T, T, F, 32'h00000102, 3'd2, F);
        tbl[2]  = mk(F, T, 8'h03, T, T, F, 32'h00010203, 3'd3, F);
        tbl[3]  = mk(F, T, 8'h04, T, T, T, 32'h01020304, 3'd4, T);
        tbl[4]  = mk(F, T, 8'h05, T, T, T, 32'h02030405, 3'd4, T);
        tbl[5]  = mk(F, T, 8'hFF, T, T, T, 32'h030405FF, 3'd4, T);
        tbl[6]  = mk(F, T, 8'h06, F, F, T, 32'h030405FF, 3'd4, T);
        tbl[7]  = mk(F, T, 8'h06, F, F, T, 32'h030405FF, 3'd4, T);
        tbl[8]  = mk(F, T, 8'h06, F, F, T, 32'h030405FF, 3'd4, T);
        tbl[9]  = mk(F, T, 8'h06, T, T, T, 32'h0405FF06, 3'd4, T);
        tbl[10] = mk(F, F, 8'h00, T, T, F, 32'h0405FF06, 3'd4, T);
        tbl[11] = mk(F, F, 8'h00, T, T, F, 32'h0405FF06, 3'd4, T);
        tbl[12] = mk(F, T, 8'h10, T, T, T, 32'h05FF0610, 3'd4, T);
        tbl[13] = mk(T, T, 8'h07, T, T, F, 32'h00000000, 3'd0, F);
        tbl[14] = mk(F, T, 8'h08, T, T, F, 32'h00000008, 3'd1, F);
        tbl[15] = mk(F, T, 8'h09, F, T, F, 32'h00000809, 3'd2, F);
        tbl[16] = mk(F, T, 8'h0A, T, T, F, 32'h0008090A, 3'd3, F);
        tbl[17] = mk(F, T, 8'h0B, F, T, T, 32'h08090A0B, 3'd4, T);
        tbl[18] = mk(F, F, 8'h00, F, F, T, 32'h08090A0B, 3'd4, T);
        tbl[19] = mk(T, F, 8'h00, F, F, F, 32'h00000000, 3'd0, F);

        // Reset state while rst_n is held low.
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("row%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].ir));
            tick();
            chk($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
            chk($sformatf("row%0d vector", i), 64'(bus.data_out_vector), 64'(tbl[i].vec));
            chk($sformatf("row%0d fill", i), 64'(bus.fill_count), 64'(tbl[i].fill));
            chk($sformatf("row%0d full", i), 64'(bus.full), 64'(tbl[i].full));
        end

        // Asynchronous reset mid-stream after three samples.
        for (int i = 1; i <= 3; i++) begin
            apply(F, T, DW'(8'h20 + i), T);
            tick();
        end
        chk("pre-reset fill", 64'(bus.fill_count), 64'd3);
        apply(F, F, 8'h00, F);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-reset fill", 64'(bus.fill_count), 64'd0);

        // Randomized traffic against the window model.
        mq.delete();
        mv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic          c, iv, ordy;
            logic [DW-1:0] d;
            c    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 7);
            d    = DW'($urandom_range(0, 255));
            apply(c, iv, d, ordy);
            chk($sformatf("rand%0d in_ready", i), 64'(bus.in_ready), 64'(!mv || ordy));
            model_step(c, iv, d, ordy);
            tick();
            chk($sformatf("rand%0d out_valid", i), 64'(bus.out_valid), 64'(mv));
            chk($sformatf("rand%0d vector", i), 64'(bus.data_out_vector), 64'(model_vec()));
            chk($sformatf("rand%0d fill", i), 64'(bus.fill_count), 64'(mq.size()));
            chk($sformatf("rand%0d full", i), 64'(bus.full), 64'(mq.size() == BS));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sma_window_buffer.md
Name: sma_window_buffer

Overview:
- Sliding-window sample buffer directly upstream of the SMA adder tree.
- Accepts one sample per handshake and holds the last BUFFER_SIZE samples.
- Presents the window as a packed vector that connects straight to the adder tree's data_in_vector input.
- Signals when a complete window is valid, so the downstream sum/average only fires on full windows.

Parameters:
- DATA_WIDTH, 8, width of one unsigned sample.
- BUFFER_SIZE, 4, window length in samples; must be >= 2.
- CNT_WIDTH, $clog2(BUFFER_SIZE+1), width of fill_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of window contents and fill state.
- in_data  input  DATA_WIDTH  incoming sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept a sample this cycle.
- out_ready  input  1  downstream consumes the current window.
- out_valid  output  1  data_out_vector holds a full, new window.
- data_out_vector  output  DATA_WIDTH*BUFFER_SIZE  window; slot k at bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH], slot 0 = newest, slot BUFFER_SIZE-1 = oldest.
- fill_count  output  CNT_WIDTH  samples held, saturates at BUFFER_SIZE.
- full  output  1  fill_count == BUFFER_SIZE.

Behaviour:
- Reset (rst_n low, async assert, sync release):
  - all slots 0, fill_count 0, full 0, out_valid 0, state FILL.
  - in_ready is 1 while in reset, because it is combinational from out_valid = 0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready && !clear.
- On accept:
  - slot k <= slot k-1 for k = BUFFER_SIZE-1..1; slot 0 <= in_data. The oldest sample is discarded.
  - fill_count increments, saturating at BUFFER_SIZE.
- State machine: FILL, RUN.
  - FILL: out_valid stays 0. Unfilled slots read 0.
    - The accept that brings fill_count to BUFFER_SIZE moves to RUN.
    - That same accept sets out_valid = 1 in the next cycle.
  - RUN: each accept sets out_valid = 1 in the next cycle.
    - A cycle with out_valid && out_ready and no accept clears out_valid next cycle.
    - Consume and accept in the same cycle keeps out_valid = 1 with the new window.
- Latency: a sample accepted at edge N appears in slot 0 and out_valid after edge N. That is one cycle, registered output.
- Backpressure: while out_valid && !out_ready:
  - data_out_vector, fill_count and out_valid are stable.
  - in_ready = 0, so no sample is lost or overwritten.
- clear (synchronous, highest priority below rst_n):
  - next edge gives slots 0, fill_count 0, full 0, out_valid 0, state FILL.
  - Any in_valid in the same cycle is dropped; the upstream source must treat it as not accepted.
  - in_ready is not gated by clear.
- fill_count never exceeds BUFFER_SIZE. There is no wrap-around; the buffer is a shift register, not circular.
- No arithmetic is performed. Sample bits pass through unmodified.
- All outputs except in_ready are registered.

Test Plan:
- Reset: assert rst_n = 0 mid-stream after 3 samples -> immediately data_out_vector = 0, fill_count = 0, out_valid = 0, full = 0; in_ready = 1.
- Warm-up (DATA_WIDTH=8, BUFFER_SIZE=4, out_ready=1): accept 0x01, 0x02, 0x03 ->
  - out_valid stays 0; fill_count goes 1, 2, 3.
  - data_out_vector = 32'h00010203 after the third sample.
  - Accept 0x04 -> next cycle out_valid = 1, full = 1, data_out_vector = 32'h01020304.
- Steady sliding: accept 0x05 then 0xFF back-to-back with out_ready=1 -> 32'h02030405, then 32'h030405FF; out_valid held 1 both cycles; fill_count stays 4.
- Backpressure: full window, out_ready = 0, in_valid = 1 with 0x06 for 3 cycles ->
  - in_ready = 0, vector unchanged, out_valid = 1 throughout.
  - Raise out_ready -> 0x06 is accepted that cycle and the next vector shifts in 0x06.
- Clear collision: in RUN, assert clear and in_valid (0x07) together ->
  - next cycle fill_count = 0, out_valid = 0, vector = 0, 0x07 not stored.
  - Four further samples are required before out_valid reasserts.
- Idle drain: full window, out_ready=1, in_valid=0 -> out_valid drops to 0 after one cycle; vector retained; full stays 1.
